// File: rtl/back_icon_channel_scheduler_if.sv
// Icon instruction handshake from front-end dispatch into the channel scheduler.
interface back_icon_channel_scheduler_if #(
  parameter int EU_ADDR_W      = 2,
  parameter int NUM_EXEC_UNITS = 4
);
  logic                        instr_valid_i;
  logic                        instr_ready_o;
  logic [EU_ADDR_W-1:0]        instr_src_addr_i;
  logic [2*NUM_EXEC_UNITS-1:0] instr_receivers_i;

  modport master (
    output instr_valid_i,
    output instr_src_addr_i,
    output instr_receivers_i,
    input  instr_ready_o
  );

  modport slave (
    input  instr_valid_i,
    input  instr_src_addr_i,
    input  instr_receivers_i,
    output instr_ready_o
  );
endinterface

// File: rtl/back_icon_channel_scheduler.sv
// Queues icon instructions and allocates them in order to free interconnect channels.
// Optional per-channel watchdog enabled by defining BACK_ICON_TIMEOUT_EN.
module back_icon_channel_scheduler #(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int NUM_EXEC_UNITS    = 4,
  parameter int EU_ADDR_W         = 2,
  parameter int QUEUE_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic clk,
  input  logic reset_n,
  back_icon_channel_scheduler_if.slave instr,
  output logic [NUM_ICON_CHANNELS*EU_ADDR_W-1:0]        ch_src_addr_o,
  output logic [NUM_ICON_CHANNELS*2*NUM_EXEC_UNITS-1:0] ch_receiver_list_o,
  input  logic [NUM_ICON_CHANNELS*2*NUM_EXEC_UNITS-1:0] ch_success_list_i,
  output logic [NUM_ICON_CHANNELS-1:0]                  ch_busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]                  fifo_count_o,
  output logic [NUM_ICON_CHANNELS-1:0]                  timeout_err_o
);

  localparam int NC = NUM_ICON_CHANNELS;
  localparam int RW = 2*NUM_EXEC_UNITS;
  localparam int EW = EU_ADDR_W;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic {
    CH_IDLE,
    CH_ACTIVE
  } ch_state_e;

  logic [EW-1:0] q_src [QUEUE_DEPTH];
  logic [RW-1:0] q_rcv [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push;
  logic          pop;
  logic          empty;
  logic          head_zero;
  logic [EW-1:0] head_src;
  logic [RW-1:0] head_rcv;

  ch_state_e     st_q  [NC];
  ch_state_e     st_d  [NC];
  logic [EW-1:0] src_q [NC];
  logic [EW-1:0] src_d [NC];
  logic [RW-1:0] out_q [NC];
  logic [RW-1:0] out_d [NC];
  logic [RW-1:0] succ  [NC];

  logic          idle_any;
  logic          conflict;
  logic          grant;
  logic [GW-1:0] gnt_idx;
  logic [NC-1:0] expire;

  assign empty     = (count_q == '0);
  assign head_src  = q_src[rd_ptr_q];
  assign head_rcv  = q_rcv[rd_ptr_q];
  assign head_zero = (head_rcv == '0);

  assign instr.instr_ready_o = (count_q < CW'(QUEUE_DEPTH));
  assign push = instr.instr_valid_i && instr.instr_ready_o;
  // Empty-bitmap entries drain without ever touching a channel.
  assign pop  = !empty && (head_zero || grant);

  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr_q] <= instr.instr_src_addr_i;
      q_rcv[wr_ptr_q] <= instr.instr_receivers_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Conflicts use registered state: a channel finishing now still blocks.
  always_comb begin
    idle_any = 1'b0;
    conflict = 1'b0;
    gnt_idx  = '0;
    for (int c = NC-1; c >= 0; c--) begin
      if (st_q[c] == CH_IDLE) begin
        idle_any = 1'b1;
        gnt_idx  = GW'(c);
      end else if ((src_q[c] == head_src) ||
                   ((out_q[c] & head_rcv) != '0)) begin
        conflict = 1'b1;
      end
    end
  end

  assign grant = !empty && !head_zero && idle_any && !conflict;

`ifdef BACK_ICON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q [NC];
  logic [TW-1:0] tcnt_d [NC];
  logic [NC-1:0] terr_q;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      expire[c] = 1'b0;
      tcnt_d[c] = '0;
      if (st_q[c] == CH_ACTIVE) begin
        tcnt_d[c] = tcnt_q[c] + TW'(1);
        expire[c] = (tcnt_d[c] == TW'(TIMEOUT_CYCLES));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NC; c++) tcnt_q[c] <= '0;
      terr_q <= '0;
    end else begin
      for (int c = 0; c < NC; c++) tcnt_q[c] <= tcnt_d[c];
      terr_q <= terr_q | expire;
    end
  end

  assign timeout_err_o = terr_q;
`else
  assign expire        = '0;
  assign timeout_err_o = '0;
`endif

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      st_d[c]  = st_q[c];
      src_d[c] = src_q[c];
      out_d[c] = out_q[c];
      unique case (st_q[c])
        CH_IDLE: begin
          if (grant && (gnt_idx == GW'(c))) begin
            st_d[c]  = CH_ACTIVE;
            src_d[c] = head_src;
            out_d[c] = head_rcv;
          end
        end
        CH_ACTIVE: begin
          out_d[c] = out_q[c] & ~succ[c];
          if ((out_d[c] == '0) || expire[c]) st_d[c] = CH_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NC; c++) begin
        st_q[c]  <= CH_IDLE;
        src_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        st_q[c]  <= st_d[c];
        src_q[c] <= src_d[c];
        out_q[c] <= out_d[c];
      end
    end
  end

  for (genvar g = 0; g < NC; g++) begin : g_ch
    assign succ[g]      = ch_success_list_i[g*RW +: RW];
    assign ch_busy_o[g] = (st_q[g] == CH_ACTIVE);
    assign ch_src_addr_o[g*EW +: EW] =
      ch_busy_o[g] ? src_q[g] : '0;
    assign ch_receiver_list_o[g*RW +: RW] =
      ch_busy_o[g] ? out_q[g] : '0;
  end

  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_back_icon_channel_scheduler.sv
// Scoreboard bench for back_icon_channel_scheduler: grants are matched in order.
module tb_back_icon_channel_scheduler;

  localparam int NC  = 4;
  localparam int NEU = 4;
  localparam int RW  = 2*NEU;
  localparam int EW  = 2;
  localparam int QD  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  back_icon_channel_scheduler_if #(
    .EU_ADDR_W(EW), .NUM_EXEC_UNITS(NEU)
  ) ifc ();

  logic [NC*EW-1:0] ch_src;
  logic [NC*RW-1:0] ch_rcv;
  logic [NC*RW-1:0] ch_succ;
  logic [NC*RW-1:0] succ_man;
  logic [NC-1:0]    busy;
  logic [2:0]       count;
  logic [NC-1:0]    terr;
  logic             auto_en;

  assign ch_succ = auto_en ? '1 : succ_man;

  back_icon_channel_scheduler #(
    .NUM_ICON_CHANNELS(NC),
    .NUM_EXEC_UNITS(NEU),
    .EU_ADDR_W(EW),
    .QUEUE_DEPTH(QD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .instr(ifc),
    .ch_src_addr_o(ch_src),
    .ch_receiver_list_o(ch_rcv),
    .ch_success_list_i(ch_succ),
    .ch_busy_o(busy),
    .fifo_count_o(count),
    .timeout_err_o(terr)
  );

  typedef struct {
    int            ch;
    logic [EW-1:0] src;
    logic [RW-1:0] rcv;
  } sb_t;

  sb_t sb[$];
  int  n_chk = 0;
  int  n_err = 0;
  logic [NC-1:0] prev_busy = '0;

  logic [EW-1:0] wsrc [6] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
  logic [RW-1:0] wrcv [6] = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h03, 8'hC0};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [EW-1:0] s, input logic [RW-1:0] r,
                      input int ch);
    bit ok = 1'b0;
    ifc.instr_valid_i     = 1'b1;
    ifc.instr_src_addr_i  = s;
    ifc.instr_receivers_i = r;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (ifc.instr_ready_o) begin
        ok = 1'b1;
        if (r != '0) sb.push_back('{ch, s, r});
      end
      tick();
    end
    ifc.instr_valid_i = 1'b0;
    chk("push_acc", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    auto_en = 1'b1;
    while (i < 64 && (busy != '0 || count != '0)) begin
      tick();
      i++;
    end
    auto_en = 1'b0;
    chk(tag, {busy, count}, '0);
  endtask

  // Each newly-busy channel must carry the oldest outstanding instruction.
  always @(negedge clk) begin
    sb_t e;
    for (int c = 0; c < NC; c++) begin
      if (busy[c] && !prev_busy[c]) begin
        if (sb.size() == 0) begin
          chk("sb_extra_ch", 64'(c), 64'(NC));
        end else begin
          e = sb.pop_front();
          if (e.ch >= 0) chk("sb_ch", 64'(c), 64'(e.ch));
          chk("sb_src", ch_src[c*EW +: EW], e.src);
          chk("sb_rcv", ch_rcv[c*RW +: RW], e.rcv);
        end
      end
    end
    prev_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.instr_valid_i     = 1'b0;
    ifc.instr_src_addr_i  = '0;
    ifc.instr_receivers_i = '0;
    succ_man = '0;
    auto_en  = 1'b0;
    tick();
    tick();
    chk("rst_ready", ifc.instr_ready_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", count, 0);
    chk("rst_src", ch_src, 0);
    chk("rst_rcv", ch_rcv, 0);
    chk("rst_terr", terr, 0);
    reset_n = 1'b1;
    tick();

    // basic flow
    push(2'd1, 8'h05, 0);
    chk("bf_t1_busy", busy, 0);
    chk("bf_t1_cnt", count, 1);
    tick();
    chk("bf_t2_busy", busy, 4'b0001);
    chk("bf_t2_src", ch_src[1:0], 2'd1);
    chk("bf_t2_rcv", ch_rcv[7:0], 8'h05);
    tick();
    succ_man[7:0] = 8'h81;
    tick();
    succ_man = '0;
    chk("bf_t4_busy", busy, 4'b0001);
    chk("bf_t4_rcv", ch_rcv[7:0], 8'h04);
    tick();
    succ_man[7:0] = 8'h04;
    tick();
    succ_man = '0;
    chk("bf_t6_busy", busy, 0);
    chk("bf_t6_rcv", ch_rcv, 0);

    // parallel allocation
    for (int i = 0; i < NC; i++) begin
      push(EW'(i), RW'(1 << (2*i)), i);
      chk("par_busy", busy, 64'((1 << i) - 1));
    end
    push(2'd0, 8'h02, 0);
    chk("par_busy4", busy, 4'hF);
    chk("par_cnt", count, 1);
    succ_man = '1;
    tick();
    succ_man = '0;
    chk("par_rel_busy", busy, 0);
    chk("par_rel_cnt", count, 1);
    tick();
    chk("par_e_busy", busy, 4'b0001);
    chk("par_e_cnt", count, 0);
    wait_idle("par_idle");

    // source conflict
    push(2'd2, 8'h01, 0);
    push(2'd2, 8'h02, 0);
    chk("sc_busy", busy, 4'b0001);
    chk("sc_cnt", count, 1);
    tick();
    tick();
    chk("sc_hold_cnt", count, 1);
    succ_man[7:0] = 8'h01;
    tick();
    succ_man = '0;
    chk("sc_done_busy", busy, 0);
    chk("sc_done_cnt", count, 1);
    tick();
    chk("sc_regrant_busy", busy, 4'b0001);
    chk("sc_regrant_cnt", count, 0);
    wait_idle("sc_idle");

    // receiver overlap
    push(2'd0, 8'h03, 0);
    push(2'd1, 8'h02, 0);
    chk("ro_busy", busy, 4'b0001);
    chk("ro_cnt", count, 1);
    tick();
    succ_man[7:0] = 8'h01;
    tick();
    succ_man = '0;
    chk("ro_part_rcv", ch_rcv[7:0], 8'h02);
    chk("ro_part_cnt", count, 1);
    succ_man[7:0] = 8'h02;
    tick();
    succ_man = '0;
    chk("ro_done_busy", busy, 0);
    chk("ro_done_cnt", count, 1);
    tick();
    chk("ro_grant_busy", busy, 4'b0001);
    chk("ro_grant_src", ch_src[1:0], 2'd1);
    wait_idle("ro_idle");

    // zero-receiver discard
    push(2'd1, 8'h00, -1);
    push(2'd2, 8'h10, 0);
    chk("zd_cnt", count, 1);
    chk("zd_busy", busy, 0);
    tick();
    chk("zd_grant_busy", busy, 4'b0001);
    wait_idle("zd_idle");

    // FIFO full and pointer wrap
    for (int i = 0; i < NC; i++) push(EW'(i), RW'(1 << (2*i)), i);
    for (int i = 0; i < NC; i++) push(EW'(i), RW'(2 << (2*i)), i);
    chk("ff_busy", busy, 4'hF);
    chk("ff_cnt", count, 4);
    chk("ff_ready", ifc.instr_ready_o, 0);
    ifc.instr_valid_i     = 1'b1;
    ifc.instr_src_addr_i  = 2'd1;
    ifc.instr_receivers_i = 8'h01;
    tick();
    ifc.instr_valid_i = 1'b0;
    chk("ff_reject_cnt", count, 4);
    succ_man = '1;
    tick();
    succ_man = '0;
    chk("ff_rel_busy", busy, 0);
    chk("ff_rel_cnt", count, 4);
    tick();
    tick();
    tick();
    tick();
    chk("ff_drain_busy", busy, 4'hF);
    chk("ff_drain_cnt", count, 0);
    wait_idle("ff_idle");
    auto_en = 1'b1;
    for (int j = 0; j < 6; j++) push(wsrc[j], wrcv[j], -1);
    wait_idle("wrap_idle");

    // reset in mid-operation
    push(2'd1, 8'h01, 0);
    push(2'd2, 8'h04, 1);
    push(2'd1, 8'h02, -1);
    chk("mr_busy", busy, 4'b0011);
    chk("mr_cnt", count, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_cnt", count, 0);
    chk("mr_rst_ready", ifc.instr_ready_o, 1);
    chk("mr_rst_src", ch_src, 0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    push(2'd3, 8'h08, 0);
    tick();
    chk("mr_after_busy", busy, 4'b0001);
    wait_idle("mr_idle");

`ifdef BACK_ICON_TIMEOUT_EN
    push(2'd1, 8'h01, 0);
    repeat (8) tick();
    chk("to_pre_busy", busy, 4'b0001);
    chk("to_pre_err", terr, 0);
    tick();
    chk("to_busy", busy, 0);
    chk("to_err", terr, 4'b0001);
    repeat (3) tick();
    chk("to_sticky", terr, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("to_rst_err", terr, 0);
    tick();
    reset_n = 1'b1;
    tick();
`else
    push(2'd1, 8'h01, 0);
    repeat (20) tick();
    chk("nto_busy", busy, 4'b0001);
    chk("nto_err", terr, 0);
    wait_idle("nto_idle");
`endif

    chk("sb_left", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
